// File: rtl/crossbar_scheduler.sv
// ============================================================================
// Module   : crossbar_scheduler
// Brief    : 4x4 crossbar scheduler, one round-robin burst-limited arbiter
//            per output, fully registered grant/select/enable outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module crossbar_scheduler #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [1:0] dst1,
    input  logic [1:0] dst2,
    input  logic [1:0] dst3,
    input  logic [1:0] dst4,
    output logic [3:0] gnt,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic [1:0] sel3,
    output logic [1:0] sel4,
    output logic [3:0] oen
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [3:0][1:0] w_dst;
    logic [3:0][1:0] w_owner;

    assign w_dst = {dst4, dst3, dst2, dst1};

    for (genvar o = 0; o < 4; o++) begin : g_arb
        state_t     state_q, state_d;
        logic [1:0] owner_q, owner_d;
        logic [1:0] ptr_q,   ptr_d;
        logic [3:0] cnt_q,   cnt_d;
        logic [3:0] w_cand;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                owner_q <= 2'd0;
                ptr_q   <= 2'd0;
                cnt_q   <= 4'd0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            logic       found;
            logic [1:0] idx;
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            cnt_d   = cnt_q;
            found   = 1'b0;
            idx     = 2'd0;
            for (int i = 0; i < 4; i++) begin
                w_cand[i] = req[i] && (w_dst[i] == 2'(o));
            end
            case (state_q)
                IDLE: begin
                    // First candidate at or after the pointer, wrapping 3->0.
                    for (int k = 0; k < 4; k++) begin
                        idx = ptr_q + 2'(k);
                        if (!found && w_cand[idx]) begin
                            found   = 1'b1;
                            owner_d = idx;
                        end
                    end
                    if (found) begin
                        state_d = BUSY;
                        cnt_d   = 4'd1;
                    end
                end
                BUSY: begin
                    if (w_cand[owner_q] && (cnt_q < c_max_burst)) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = owner_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Owner is retained in IDLE, so it doubles as the held select value.
        assign w_owner[o] = owner_q;
        assign oen[o]     = (state_q == BUSY);
    end

    assign sel1 = w_owner[0];
    assign sel2 = w_owner[1];
    assign sel3 = w_owner[2];
    assign sel4 = w_owner[3];

    always_comb begin
        gnt = 4'b0000;
        for (int o = 0; o < 4; o++) begin
            if (oen[o]) begin
                gnt[w_owner[o]] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crossbar_scheduler.sv
// ============================================================================
// Module   : tb_crossbar_scheduler
// Brief    : Directed and randomized checks of crossbar_scheduler against a
//            per-output behavioural arbitration model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_crossbar_scheduler;

    localparam int MAXB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] dst [4];
    logic [3:0] gnt;
    logic [3:0] oen;
    logic [1:0] sel1, sel2, sel3, sel4;

    int n_total;
    int n_bad;

    int m_busy [4];
    int m_own  [4];
    int m_cnt  [4];
    int m_ptr  [4];

    crossbar_scheduler #(.MAX_BURST(MAXB)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dst1 (dst[0]),
        .dst2 (dst[1]),
        .dst3 (dst[2]),
        .dst4 (dst[3]),
        .gnt  (gnt),
        .sel1 (sel1),
        .sel2 (sel2),
        .sel3 (sel3),
        .sel4 (sel4),
        .oen  (oen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            m_busy[o] = 0; m_own[o] = 0; m_cnt[o] = 0; m_ptr[o] = 0;
        end
    endtask

    // Applies one clock edge of the arbitration rules to every output.
    task automatic model_step();
        for (int o = 0; o < 4; o++) begin
            if (m_busy[o] != 0) begin
                if (req[m_own[o]] && int'(dst[m_own[o]]) == o && m_cnt[o] < MAXB) begin
                    m_cnt[o]++;
                end else begin
                    m_busy[o] = 0;
                    m_ptr[o]  = (m_own[o] + 1) % 4;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % 4;
                    if (m_busy[o] == 0 && req[i] && int'(dst[i]) == o) begin
                        m_busy[o] = 1; m_own[o] = i; m_cnt[o] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] e_oen;
        logic [3:0] e_gnt;
        e_oen = '0;
        e_gnt = '0;
        for (int o = 0; o < 4; o++) begin
            if (m_busy[o] != 0) begin
                e_oen[o] = 1'b1;
                e_gnt[m_own[o]] = 1'b1;
            end
        end
        check("oen", 32'(oen), 32'(e_oen));
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("sel1", 32'(sel1), 32'(m_own[0]));
        check("sel2", 32'(sel2), 32'(m_own[1]));
        check("sel3", 32'(sel3), 32'(m_own[2]));
        check("sel4", 32'(sel4), 32'(m_own[3]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_in(input logic [3:0] r, input logic [1:0] d0, input logic [1:0] d1,
                          input logic [1:0] d2, input logic [1:0] d3);
        req = r; dst[0] = d0; dst[1] = d1; dst[2] = d2; dst[3] = d3;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        set_in(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
        model_reset();
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_oen", 32'(oen), 32'h0);
        check("rst_sel", 32'({sel4, sel3, sel2, sel1}), 32'h0);
        do_reset();

        // Single requester: 4 busy, 1 idle, repeating.
        set_in(4'b0001, 2'd2, 2'd0, 2'd0, 2'd0);
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("single_oen", 32'(oen), ((c % 5) != 4) ? 32'h4 : 32'h0);
            check("single_gnt", 32'(gnt), ((c % 5) != 4) ? 32'h1 : 32'h0);
        end

        // Parallel grants.
        set_in(4'b0000, 2'd3, 2'd2, 2'd1, 2'd0);
        cycle(); cycle();
        req = 4'b1111;
        cycle();
        check("par_oen", 32'(oen), 32'hF);
        check("par_gnt", 32'(gnt), 32'hF);
        check("par_sel", 32'({sel4, sel3, sel2, sel1}), 32'({2'd0, 2'd1, 2'd2, 2'd3}));

        // Conflict on out1 with an asynchronous reset mid-burst.
        do_reset();
        set_in(4'b1111, 2'd0, 2'd0, 2'd0, 2'd0);
        for (int c = 0; c < 22; c++) begin
            cycle();
            check("conf_gnt", 32'(gnt), ((c % 5) != 4) ? (32'h1 << ((c / 5) % 4)) : 32'h0);
            if ((c % 5) != 4) check("conf_sel1", 32'(sel1), 32'((c / 5) % 4));
        end
        #3;
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'h0);
        check("arst_oen", 32'(oen), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // Early drop: pointer moves past in2 so in3 beats in1.
        do_reset();
        set_in(4'b0010, 2'd1, 2'd1, 2'd1, 2'd0);
        cycle(); cycle();
        check("drop_gnt", 32'(gnt), 32'h2);
        req = 4'b0101;
        cycle();
        check("drop_oen", 32'(oen), 32'h0);
        cycle();
        check("drop_win", 32'(gnt), 32'h4);
        check("drop_sel2", 32'(sel2), 32'h2);

        // Redirect: in1 moves from out1 to out2 on the same edge.
        do_reset();
        set_in(4'b0001, 2'd0, 2'd3, 2'd3, 2'd3);
        cycle();
        check("redir_oen0", 32'(oen), 32'h1);
        dst[0] = 2'd1;
        cycle();
        check("redir_oen1", 32'(oen), 32'h2);
        check("redir_gnt", 32'(gnt), 32'h1);

        // Randomized traffic, biased toward conflicts.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0)
                    dst[i] = ($urandom_range(1) == 0) ? 2'($urandom_range(1)) : 2'($urandom);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crossbar_scheduler.md
CROSSBAR_SCHEDULER -- requirements
Module: crossbar_scheduler

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning max consecutive cycles one input may own one output (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  4  req[i] = input i+1 requests a path.
REQ-005 SHALL have ports dst1..dst4  input  2 each  requested output for input 1..4 (0 = out1 .. 3 = out4).
REQ-006 SHALL have port gnt  output  4  gnt[i] = input i+1 currently owns its requested output.
REQ-007 SHALL have ports sel1..sel4  output  2 each  input index (0 = in1 .. 3 = in4) driving out1..out4.
REQ-008 SHALL have port oen  output  4  oen[o] = output o+1 is driven by its sel value.

Function
REQ-009 SHALL contain four independent per-output arbiters, each with state IDLE/BUSY, 2-bit owner, 4-bit burst counter and 2-bit round-robin pointer.
REQ-010 Candidate set for output o SHALL be all inputs i with req[i]=1 and dst(i)=o, sampled at the clock edge.
REQ-011 IDLE -> BUSY SHALL occur on the edge where the candidate set is non-empty: owner = first candidate scanning from pointer upward, wrapping 3->0; counter = 1.
REQ-012 Grant latency SHALL be one cycle: a request sampled at edge t yields gnt/oen/sel valid after edge t.
REQ-013 In BUSY, ownership SHALL be held while req[owner]=1, dst(owner)=o and counter<MAX_BURST; the counter increments each held cycle.
REQ-014 BUSY -> IDLE SHALL occur on the edge where req[owner]=0, dst(owner)!=o, or counter=MAX_BURST; pointer SHALL become owner+1 mod 4 on that edge.
REQ-015 After a release, the output SHALL spend exactly one cycle IDLE with oen[o]=0 before re-arbitrating, including when the same input still requests.
REQ-016 sel of output o SHALL equal owner while BUSY and SHALL hold its last value while IDLE.
REQ-017 oen[o] SHALL be 1 iff output o is BUSY.
REQ-018 gnt[i] SHALL be 1 iff some output is BUSY with owner i; since each input names one dst, at most one output owns an input.
REQ-019 Several outputs SHALL be grantable in the same cycle; a conflict exists only among requesters naming the same output.
REQ-020 A requester that loses arbitration SHALL keep requesting without penalty; its own req/dst changes take effect at the next sample.
REQ-021 Outputs and next-state SHALL be purely registered; no combinational path from req/dst to gnt/sel/oen.

Reset
REQ-022 While rst=1, every arbiter SHALL be IDLE; owner, counter and sel1..sel4 SHALL be 0; pointers SHALL be 0; gnt=4'b0000; oen=4'b0000.
REQ-023 Reset asserted mid-burst SHALL drop gnt/oen immediately (asynchronously), without waiting for a clock.
REQ-024 After rst deasserts, the first sampling edge SHALL arbitrate from pointer 0.

Verification
REQ-025 Single request: req=0001, dst1=2, held 10 cycles -> gnt=0001, sel3=0, oen=0100 one cycle later; released after 4 cycles; 1 idle cycle; regranted; pattern repeats.
REQ-026 Conflict: req=1111, all dst=0 -> out1 owned by in1, in2, in3, in4, then in1, each 4 cycles; one idle cycle between owners; gnt one-hot.
REQ-027 Parallel: dst1=3, dst2=2, dst3=1, dst4=0, req=1111 -> oen=1111 and sel1=3, sel2=2, sel3=1, sel4=0 in the same cycle; gnt=1111.
REQ-028 Early drop: in2 granted out2 (dst2=1), req[1] falls after 2 cycles -> oen[1]=0 the next cycle; pointer=2; then waiting in1 and in3 -> in3 wins.
REQ-029 Redirect: in1 owns out1, dst1 changes to 1 -> out1 releases on that edge; out2 is granted to in1 on the same edge if out2 is IDLE.
REQ-030 Reset mid-burst: rst pulsed asynchronously between edges during REQ-026 -> gnt=0000 and oen=0000 immediately; after release, in1 is granted first.
